cve2_fp_rf_sb: RTL and testbench
================================

// Module: cve2_fp_rf_sb
// PURPOSE
//  Floating-point register file and load scoreboard; the consumer of the FP writeback port.
//  Accepts FP register writes from the writeback stage.
//  Serves three combinational read ports (rs1/rs2/rs3 for FMA) to ID.
//  Tracks outstanding FP loads in an in-order FIFO, so ID can stall on read-after-load hazards.
// PARAMETERS
//  DataWidth  32  width of each FP register
//  LdDepth    2   max outstanding FP loads tracked (1..4)
// PORTS
//  clk_i                 in   1   clock
//  rst_i                 in   1   asynchronous reset, active-high
//  rf_fp_raddr_{a,b,c}_i in   5   read addresses (rs1, rs2, rs3)
//  rf_fp_rdata_{a,b,c}_o out  DW  read data
//  rf_fp_busy_{a,b,c}_o  out  1   read address has a pending load; ID must stall
//  rf_fp_waddr_wb_i      in   5   write address from writeback
//  rf_fp_wdata_wb_i      in   DW  write data from writeback
//  rf_fp_we_wb_i         in   1   write enable from writeback
//  ld_issue_i            in   1   ID issues an FP load (valid)
//  ld_issue_addr_i       in   5   destination FP register of the issued load
//  ld_issue_ready_o      out  1   scoreboard can accept an issue
//  lsu_resp_valid_i      in   1   LSU response for the oldest load
//  lsu_resp_err_i        in   1   that response is an error (no RF write follows)
//  flush_i               in   1   exception/flush: drop all pending loads
//  ld_pending_o          out  1   at least one load outstanding
// BEHAVIOUR
//  - Reset: all 32 registers = 0; FIFO empty (count=0, rd/wr ptr=0).
//    Outputs during reset: ld_issue_ready_o=1, busy_*=0, ld_pending_o=0, rdata_*=0.
//  - f0 is a real register (not hardwired zero).
//  - Write: on posedge with rf_fp_we_wb_i=1, reg[waddr] <= wdata.
//  - Read: combinational, zero latency. Same-cycle write is visible next cycle (see CONFIGURATION).
//  - FIFO: LdDepth entries of 5-bit addr + valid; count in 0..LdDepth.
//    Pointers wrap modulo LdDepth.
//  - Push: ld_issue_i & ld_issue_ready_o. ld_issue_ready_o = (count != LdDepth); no pop-through.
//    Issue while full is ignored; asserting it is an assertion failure.
//  - Pop: lsu_resp_valid_i & count!=0 removes the head, whether or not the response is an error.
//    A response while empty is ignored and flagged by an assertion.
//  - Simultaneous push & pop: both happen, count unchanged.
//    Allowed when full only if ready was already 1 (it is not), so at most one of them occurs when full.
//  - busy_x = OR over valid entries of (entry.addr == raddr_x).
//    Duplicate addresses are allowed; busy stays set until the last matching entry pops.
//  - flush_i: count, pointers and valid bits go to 0 on the next edge; it overrides a same-cycle push/pop.
//    Register contents are unaffected.
//  - Writes from WB never clear busy; only pop/flush do.
//  - ld_pending_o = (count != 0).
//  - Reset asserted mid-operation clears the FIFO and registers immediately (async).
// CONFIGURATION
//  CVE2_FP_RF_BYPASS_EN defined: write-through.
//    If rf_fp_we_wb_i and waddr==raddr_x, rdata_x = rf_fp_wdata_wb_i in the same cycle.
//    If the matching entry is the head and lsu_resp_valid_i & !lsu_resp_err_i, busy_x is 0 that cycle.
//  Undefined: no bypass; rdata shows the old value until the cycle after the write, and busy clears
//  the cycle after the pop.
// TESTING
//  1 Reset, then read all of f0..f31 -> all 0; ready=1; pending=0.
//  2 Write f3=0x3F800000, read a=f3 next cycle -> 0x3F800000.
//    Same cycle: 0x3F800000 with BYPASS_EN, old value 0 without it.
//  3 Issue loads to f5 then f5; one response -> busy_a(f5)=1; second response -> busy_a=0, pending=0.
//  4 LdDepth=2: issue f1, f2 -> ready=0; issue f4 is dropped; response -> ready=1; busy(f4)=0.
//  5 Issue f7, then response with err=1 -> entry popped, busy(f7)=0, reg f7 unchanged.
//  6 Issue f8, f9, then flush_i together with an issue of f10 -> count=0, all busy=0, f10 not tracked.

Source files
------------

// File: rtl/cve2_fp_rf_sb.sv
// rtl/cve2_fp_rf_sb.sv - FP register file with in-order load scoreboard.
// Optional write-through bypass: define CVE2_FP_RF_BYPASS_EN.
module cve2_fp_rf_sb #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LdDepth   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           rf_fp_raddr_a_i,
    input  logic [4:0]           rf_fp_raddr_b_i,
    input  logic [4:0]           rf_fp_raddr_c_i,
    output logic [DataWidth-1:0] rf_fp_rdata_a_o,
    output logic [DataWidth-1:0] rf_fp_rdata_b_o,
    output logic [DataWidth-1:0] rf_fp_rdata_c_o,
    output logic                 rf_fp_busy_a_o,
    output logic                 rf_fp_busy_b_o,
    output logic                 rf_fp_busy_c_o,
    input  logic [4:0]           rf_fp_waddr_wb_i,
    input  logic [DataWidth-1:0] rf_fp_wdata_wb_i,
    input  logic                 rf_fp_we_wb_i,
    input  logic                 ld_issue_i,
    input  logic [4:0]           ld_issue_addr_i,
    output logic                 ld_issue_ready_o,
    input  logic                 lsu_resp_valid_i,
    input  logic                 lsu_resp_err_i,
    input  logic                 flush_i,
    output logic                 ld_pending_o
);

    localparam int unsigned PtrW = (LdDepth > 1) ? $clog2(LdDepth) : 1;
    localparam int unsigned CntW = $clog2(LdDepth + 1);

    logic [DataWidth-1:0] rf_q [32];

    logic [4:0]         ent_addr_q [LdDepth];
    logic [4:0]         ent_addr_d [LdDepth];
    logic [LdDepth-1:0] ent_vld_q, ent_vld_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic push, pop, head_retire;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(LdDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_fp_we_wb_i) begin
            rf_q[rf_fp_waddr_wb_i] <= rf_fp_wdata_wb_i;
        end
    end

    assign ld_issue_ready_o = (cnt_q != CntW'(LdDepth));
    assign ld_pending_o     = (cnt_q != '0);
    assign push             = ld_issue_i & ld_issue_ready_o;
    assign pop              = lsu_resp_valid_i & (cnt_q != '0);

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_vld_d  = ent_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (flush_i) begin
            ent_vld_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            cnt_d     = '0;
        end else begin
            // push and pop never target the same slot: a push needs a free slot
            if (pop) begin
                ent_vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d            = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                ent_addr_d[wr_ptr_q] = ld_issue_addr_i;
                ent_vld_d[wr_ptr_q]  = 1'b1;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LdDepth; i++) ent_addr_q[i] <= '0;
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_vld_q  <= ent_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef CVE2_FP_RF_BYPASS_EN
    // a successful head response releases its register in the same cycle
    assign head_retire = pop & ~lsu_resp_err_i;
`else
    assign head_retire = 1'b0;
`endif

    function automatic logic busy_of(input logic [4:0] ra);
        logic b;
        b = 1'b0;
        for (int i = 0; i < LdDepth; i++) begin
            if (ent_vld_q[i] && (ent_addr_q[i] == ra) &&
                !(head_retire && (rd_ptr_q == PtrW'(i)))) begin
                b = 1'b1;
            end
        end
        return b;
    endfunction

    function automatic logic [DataWidth-1:0] rdata_of(input logic [4:0] ra);
        logic [DataWidth-1:0] d;
        d = rf_q[ra];
`ifdef CVE2_FP_RF_BYPASS_EN
        if (rf_fp_we_wb_i && !rst_i && (rf_fp_waddr_wb_i == ra)) d = rf_fp_wdata_wb_i;
`endif
        return d;
    endfunction

    assign rf_fp_busy_a_o  = busy_of(rf_fp_raddr_a_i);
    assign rf_fp_busy_b_o  = busy_of(rf_fp_raddr_b_i);
    assign rf_fp_busy_c_o  = busy_of(rf_fp_raddr_c_i);
    assign rf_fp_rdata_a_o = rdata_of(rf_fp_raddr_a_i);
    assign rf_fp_rdata_b_o = rdata_of(rf_fp_raddr_b_i);
    assign rf_fp_rdata_c_o = rdata_of(rf_fp_raddr_c_i);

    // protocol misuse is tolerated by the logic above but flagged here
    issue_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ld_issue_i && !ld_issue_ready_o))
        else $warning("load issue while scoreboard full dropped");
    resp_when_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(lsu_resp_valid_i && (cnt_q == '0)))
        else $warning("LSU response with no load outstanding ignored");

endmodule

// File: tb/tb_cve2_fp_rf_sb.sv
// tb/tb_cve2_fp_rf_sb.sv - scoreboard bench for cve2_fp_rf_sb.
module tb_cve2_fp_rf_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr_a = '0, raddr_b = '0, raddr_c = '0;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        busy_a, busy_b, busy_c;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        issue = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        ready;
    logic        resp = 1'b0, err = 1'b0, flush = 1'b0;
    logic        pending;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rf [32];
    logic [4:0]  m_ld [$];
    string       tag_q [$];
    logic [31:0] val_q [$];
    logic [31:0] saved;

    cve2_fp_rf_sb #(.DataWidth(32), .LdDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .rf_fp_raddr_a_i(raddr_a), .rf_fp_raddr_b_i(raddr_b), .rf_fp_raddr_c_i(raddr_c),
        .rf_fp_rdata_a_o(rdata_a), .rf_fp_rdata_b_o(rdata_b), .rf_fp_rdata_c_o(rdata_c),
        .rf_fp_busy_a_o(busy_a), .rf_fp_busy_b_o(busy_b), .rf_fp_busy_c_o(busy_c),
        .rf_fp_waddr_wb_i(waddr), .rf_fp_wdata_wb_i(wdata), .rf_fp_we_wb_i(we),
        .ld_issue_i(issue), .ld_issue_addr_i(issue_addr), .ld_issue_ready_o(ready),
        .lsu_resp_valid_i(resp), .lsu_resp_err_i(err), .flush_i(flush),
        .ld_pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        logic [31:0] d;
        d = m_rf[ra];
`ifdef CVE2_FP_RF_BYPASS_EN
        if (we && !rst && waddr == ra) d = wdata;
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        int start;
        start = 0;
`ifdef CVE2_FP_RF_BYPASS_EN
        if (resp && !err && m_ld.size() > 0) start = 1;
`endif
        for (int i = start; i < m_ld.size(); i++)
            if (m_ld[i] == ra) return 1'b1;
        return 1'b0;
    endfunction

    // expected read data is queued at drive time and retired when outputs are sampled
    task automatic observe();
        tag_q.push_back("rdata_a"); val_q.push_back(exp_rd(raddr_a));
        tag_q.push_back("rdata_b"); val_q.push_back(exp_rd(raddr_b));
        tag_q.push_back("rdata_c"); val_q.push_back(exp_rd(raddr_c));
        #1;
        check(tag_q.pop_front(), rdata_a, val_q.pop_front());
        check(tag_q.pop_front(), rdata_b, val_q.pop_front());
        check(tag_q.pop_front(), rdata_c, val_q.pop_front());
        check("busy_a", {31'b0, busy_a}, {31'b0, exp_busy(raddr_a)});
        check("busy_b", {31'b0, busy_b}, {31'b0, exp_busy(raddr_b)});
        check("busy_c", {31'b0, busy_c}, {31'b0, exp_busy(raddr_c)});
        check("ready", {31'b0, ready}, {31'b0, (m_ld.size() < 2)});
        check("pending", {31'b0, pending}, {31'b0, (m_ld.size() != 0)});
    endtask

    task automatic tick();
        logic do_push, do_pop;
        do_push = issue && (m_ld.size() < 2);
        do_pop  = resp && (m_ld.size() > 0);
        if (we) m_rf[waddr] = wdata;
        if (flush) m_ld.delete();
        else begin
            if (do_pop) void'(m_ld.pop_front());
            if (do_push) m_ld.push_back(issue_addr);
        end
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; issue = 1'b0; resp = 1'b0; err = 1'b0; flush = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] a);
        issue = 1'b1; issue_addr = a;
        observe();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        #2;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_pending", {31'b0, pending}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: all registers read back zero after reset
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(i + 1); raddr_c = 5'(i + 2);
            observe();
            check("t1_zero", rdata_a, 32'd0);
        end

        // 2: write f3, same-cycle and next-cycle visibility
        raddr_a = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h3F80_0000;
        observe();
`ifdef CVE2_FP_RF_BYPASS_EN
        check("t2_same", rdata_a, 32'h3F80_0000);
`else
        check("t2_same", rdata_a, 32'd0);
`endif
        tick();
        observe();
        check("t2_next", rdata_a, 32'h3F80_0000);

        // 3: duplicate loads to f5; a WB write does not clear busy
        raddr_a = 5'd5;
        do_issue(5'd5);
        do_issue(5'd5);
        we = 1'b1; waddr = 5'd5; wdata = 32'h4000_0000;
        observe();
        tick();
        check("t3_busy_wb", {31'b0, busy_a}, 32'd1);
        resp = 1'b1;
        observe();
        tick();
        observe();
        check("t3_busy_one", {31'b0, busy_a}, 32'd1);
        resp = 1'b1;
        observe();
        tick();
        observe();
        check("t3_busy_done", {31'b0, busy_a}, 32'd0);
        check("t3_pending", {31'b0, pending}, 32'd0);

        // 4: fill to depth, overflow issue dropped
        raddr_a = 5'd1; raddr_b = 5'd2; raddr_c = 5'd4;
        do_issue(5'd1);
        do_issue(5'd2);
        observe();
        check("t4_full", {31'b0, ready}, 32'd0);
        do_issue(5'd4);
        resp = 1'b1;
        observe();
        tick();
        observe();
        check("t4_ready", {31'b0, ready}, 32'd1);
        check("t4_busy_f4", {31'b0, busy_c}, 32'd0);
        resp = 1'b1;
        observe();
        tick();

        // 5: error response pops without writing
        raddr_b = 5'd7;
        saved = m_rf[7];
        do_issue(5'd7);
        resp = 1'b1; err = 1'b1;
        observe();
        check("t5_err_busy", {31'b0, busy_b}, 32'd1);
        tick();
        observe();
        check("t5_busy", {31'b0, busy_b}, 32'd0);
        check("t5_f7", rdata_b, saved);

        // 6: flush overrides a same-cycle issue
        raddr_a = 5'd8; raddr_b = 5'd9; raddr_c = 5'd10;
        do_issue(5'd8);
        do_issue(5'd9);
        flush = 1'b1; issue = 1'b1; issue_addr = 5'd10;
        observe();
        tick();
        observe();
        check("t6_pending", {31'b0, pending}, 32'd0);
        check("t6_busy_c", {31'b0, busy_c}, 32'd0);

        // random legal traffic
        for (int n = 0; n < 300; n++) begin
            raddr_a = 5'($urandom_range(0, 31));
            raddr_b = 5'($urandom_range(0, 7));
            raddr_c = 5'($urandom_range(0, 7));
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            issue = (m_ld.size() < 2) && ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            resp  = (m_ld.size() > 0) && ($urandom_range(0, 2) == 0);
            err   = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            observe();
            tick();
        end

        // asynchronous reset mid-operation
        raddr_a = 5'd12;
        we = 1'b1; waddr = 5'd12; wdata = 32'hDEAD_BEEF;
        tick();
        do_issue(5'd12);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pending", {31'b0, pending}, 32'd0);
        check("arst_busy", {31'b0, busy_a}, 32'd0);
        check("arst_rdata", rdata_a, 32'd0);
        check("arst_ready", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_ld.delete();
        @(negedge clk);
        rst = 1'b0;
        observe();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
